jk_bank_arbiter: RTL and testbench

//   Shares one WIDTH-bit bank of JK flip-flops between NREQ requesters.

---
 rtl/jk_bank_arbiter_pkg.sv | 17 +
 rtl/jk_bank_arbiter_if.sv | 24 ++
 rtl/jk_bank_arbiter_ff.sv | 26 ++
 rtl/jk_bank_arbiter.sv | 125 ++++++++++++
 tb/tb_jk_bank_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/jk_bank_arbiter_pkg.sv
// Shared types for the JK bank arbiter: command encodings and FSM state names.
package jk_pkg;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_RST  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } jk_state_t;

endpackage

// File: rtl/jk_bank_arbiter_if.sv
// Requester-facing bus of the JK bank arbiter; per-requester fields are packed by index.
interface jk_bank_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0][1:0]        req_op;
    logic [NREQ-1:0][WIDTH-1:0]  req_mask;
    logic [NREQ-1:0]             req_ready;
    logic [$clog2(NREQ)-1:0]     grant_id;
    logic                        busy;
    logic [WIDTH-1:0]            q;
    logic [WIDTH-1:0]            q1;

    modport master (
        output req_valid, req_op, req_mask,
        input  req_ready, grant_id, busy, q, q1
    );

    modport slave (
        input  req_valid, req_op, req_mask,
        output req_ready, grant_id, busy, q, q1
    );
endinterface

// File: rtl/jk_bank_arbiter_ff.sv
// One-bit JK flip-flop with asynchronous active-low reset to q=0.
module jk_flipflop_r
    import jk_pkg::*;
(
    input  logic c,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q1
);
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            case (jk_op_t'({j, k}))
                JK_RST:  q <= 1'b0;
                JK_SET:  q <= 1'b1;
                JK_TGL:  q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign q1 = ~q;
endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing one JK flop bank among NREQ requesters (IDLE->APPLY->DONE).
// Build option JK_PRIO_EN: requester 0 always wins when valid; the rest rotate among themselves.
module jk_bank_arbiter
    import jk_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic              c,
    input  logic              rst_n,
    jk_bank_arbiter_if.slave  bus
);
    localparam int GW = $clog2(NREQ);
    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_APPLY = ST_APPLY;
    localparam logic [1:0] S_DONE  = ST_DONE;

    logic [1:0]       state_q, state_d;
    logic [GW-1:0]    rr_q, rr_d;
    logic [GW-1:0]    grant_q, grant_d;
    jk_op_t           op_q, op_d;
    logic [WIDTH-1:0] mask_q, mask_d;

    logic             win_vld;
    logic [GW-1:0]    win_id;
    logic [NREQ-1:0]  cand;

    // Scan from farthest to nearest so the first valid index after rr_q is the last one kept.
    always_comb begin
        int idx;
        idx     = 0;
        cand    = bus.req_valid;
`ifdef JK_PRIO_EN
        cand[0] = 1'b0;
`endif
        win_vld = 1'b0;
        win_id  = '0;
        for (int off = NREQ; off >= 1; off--) begin
            idx = int'(rr_q) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            if (cand[GW'(idx)]) begin
                win_vld = 1'b1;
                win_id  = GW'(idx);
            end
        end
`ifdef JK_PRIO_EN
        if (bus.req_valid[0]) begin
            win_vld = 1'b1;
            win_id  = '0;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        op_d    = op_q;
        mask_d  = mask_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    grant_d = win_id;
                    op_d    = jk_op_t'(bus.req_op[win_id]);
                    mask_d  = bus.req_mask[win_id];
                    state_d = S_APPLY;
                end
            end
            S_APPLY: state_d = S_DONE;
            S_DONE: begin
                state_d = S_IDLE;
`ifdef JK_PRIO_EN
                if (grant_q != '0) rr_d = grant_q;
`else
                rr_d = grant_q;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rr_q    <= GW'(NREQ - 1);
            grant_q <= '0;
            op_q    <= JK_HOLD;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            op_q    <= op_d;
            mask_q  <= mask_d;
        end
    end

    logic             apply;
    logic [WIDTH-1:0] j, k, q_bank, q1_bank;

    assign apply = (state_q == S_APPLY);
    assign j     = apply ? (mask_q & {WIDTH{op_q[1]}}) : '0;
    assign k     = apply ? (mask_q & {WIDTH{op_q[0]}}) : '0;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        jk_flipflop_r u_ff (
            .c     (c),
            .rst_n (rst_n),
            .j     (j[b]),
            .k     (k[b]),
            .q     (q_bank[b]),
            .q1    (q1_bank[b])
        );
    end

    always_comb begin
        bus.req_ready = '0;
        if (state_q == S_DONE) bus.req_ready[grant_q] = 1'b1;
    end

    assign bus.grant_id = grant_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.q        = q_bank;
    assign bus.q1       = q1_bank;
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed and randomized bench for jk_bank_arbiter against a transaction-level model.
module tb_jk_bank_arbiter;
    import jk_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic c = 1'b0;
    logic rst_n = 1'b0;
    always #5 c = ~c;

    jk_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    jk_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .c     (c),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: one command in flight at a time; it is latched, applied one edge later,
    // acknowledged the cycle after that, and the arbiter is free again next edge.
    int             m_phase;   // 0 free, 1 command latched, 2 command applied / acking
    int             m_last;
    int             m_cur;
    logic [1:0]     m_op;
    logic [7:0]     m_mask;
    logic [7:0]     m_q;
    logic [NREQ-1:0] hold;

    task automatic model_reset();
        m_phase = 0;
        m_last  = NREQ - 1;
        m_cur   = 0;
        m_q     = 8'h00;
    endtask

    function automatic int pick(input logic [NREQ-1:0] v);
`ifdef JK_PRIO_EN
        if (v[0]) return 0;
`endif
        for (int off = 1; off <= NREQ; off++) begin
            int id;
            id = (m_last + off) % NREQ;
`ifdef JK_PRIO_EN
            if (id == 0) continue;
`endif
            if (v[id]) return id;
        end
        return -1;
    endfunction

    task automatic model_step();
        int w;
        if (!rst_n) begin
            model_reset();
        end else begin
            case (m_phase)
                0: begin
                    w = pick(bus.req_valid);
                    if (w >= 0) begin
                        m_cur   = w;
                        m_op    = bus.req_op[w];
                        m_mask  = bus.req_mask[w];
                        m_phase = 1;
                    end
                end
                1: begin
                    case (m_op)
                        2'b01:   m_q = m_q & ~m_mask;
                        2'b10:   m_q = m_q | m_mask;
                        2'b11:   m_q = m_q ^ m_mask;
                        default: m_q = m_q;
                    endcase
                    m_phase = 2;
                end
                default: begin
`ifdef JK_PRIO_EN
                    if (m_cur != 0) m_last = m_cur;
`else
                    m_last = m_cur;
`endif
                    m_phase = 0;
                end
            endcase
        end
    endtask

    task automatic compare();
        logic [NREQ-1:0] er;
        logic [7:0]      eq1;
        er  = '0;
        if (m_phase == 2) er[m_cur] = 1'b1;
        eq1 = ~m_q;
        chk("q",        32'(bus.q),         32'(m_q));
        chk("q1",       32'(bus.q1),        32'(eq1));
        chk("ready",    32'(bus.req_ready), 32'(er));
        chk("busy",     32'(bus.busy),      32'(m_phase != 0));
        chk("grant_id", 32'(bus.grant_id),  32'(m_cur));
    endtask

    task automatic cycle();
        @(posedge c);
        model_step();
        @(negedge c);
        compare();
    endtask

    task automatic set_req(input int id, input jk_op_t op, input logic [7:0] mask);
        bus.req_valid[id] = 1'b1;
        bus.req_op[id]    = op;
        bus.req_mask[id]  = mask;
    endtask

    task automatic drop_acked();
        for (int i = 0; i < NREQ; i++)
            if (bus.req_ready[i]) bus.req_valid[i] = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        model_reset();
        @(negedge c);
        rst_n = 1'b1;
    endtask

    task automatic rand_drive();
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_ready[i]) begin
                hold[i] = 1'b0;
                bus.req_valid[i] = 1'b0;
            end
            if (!hold[i]) begin
                if ($urandom_range(3) == 0) begin
                    hold[i] = 1'b1;
                    bus.req_valid[i] = 1'b1;
                    bus.req_op[i] = 2'($urandom_range(3));
                    case ($urandom_range(3))
                        0:       bus.req_mask[i] = 8'h00;
                        1:       bus.req_mask[i] = 8'hFF;
                        default: bus.req_mask[i] = 8'($urandom);
                    endcase
                end
            end else if (m_phase != 0 && m_cur == i && !bus.req_ready[i]) begin
                // Latched already: scrambling or dropping the request must not matter.
                if ($urandom_range(3) == 0) bus.req_valid[i] = 1'b0;
                bus.req_op[i]   = 2'($urandom_range(3));
                bus.req_mask[i] = 8'($urandom);
            end
        end
    endtask

    int acks[NREQ];
    int ack_seq[$];

    initial begin
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_mask  = '0;
        hold          = '0;
        model_reset();
        repeat (2) @(negedge c);
        compare();
        rst_n = 1'b1;

        // Single set, toggle, reset, and no-op commands.
        set_req(0, JK_SET, 8'h0F);
        repeat (3) begin cycle(); drop_acked(); end
        chk("t2_q", 32'(bus.q), 32'h0F);
        set_req(1, JK_TGL, 8'hFF);
        repeat (3) begin cycle(); drop_acked(); end
        chk("t3_tgl_q", 32'(bus.q), 32'hF0);
        set_req(1, JK_RST, 8'h30);
        repeat (3) begin cycle(); drop_acked(); end
        chk("t3_rst_q", 32'(bus.q), 32'hC0);
        set_req(2, JK_HOLD, 8'hFF);
        repeat (3) begin cycle(); drop_acked(); end
        chk("t5_hold_q", 32'(bus.q), 32'hC0);
        set_req(3, JK_TGL, 8'h00);
        repeat (3) begin cycle(); drop_acked(); end
        chk("t5_mask0_q", 32'(bus.q), 32'hC0);

        // Asynchronous reset while a command is in APPLY.
        set_req(0, JK_SET, 8'hFF);
        cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("t1_q",     32'(bus.q),         32'h00);
        chk("t1_q1",    32'(bus.q1),        32'hFF);
        chk("t1_ready", 32'(bus.req_ready), 32'h0);
        chk("t1_busy",  32'(bus.busy),      32'h0);
        bus.req_valid = '0;
        model_reset();
        @(negedge c);
        rst_n = 1'b1;
        compare();

        // Fairness: everyone valid, each drops after its ack.
        for (int i = 0; i < NREQ; i++) set_req(i, JK_TGL, 8'(1 << i));
        ack_seq = {};
        repeat (12) begin
            cycle();
            for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) ack_seq.push_back(i);
            drop_acked();
        end
        chk("t4_q", 32'(bus.q), 32'h0F);
        chk("t4_nacks", 32'(ack_seq.size()), 32'd4);
        for (int i = 0; i < ack_seq.size() && i < 4; i++)
            chk("t4_order", 32'(ack_seq[i]), 32'(i));

        // Requesters 0 and 2 held continuously.
        pulse_reset();
        set_req(0, JK_TGL, 8'h01);
        set_req(2, JK_TGL, 8'h04);
        for (int i = 0; i < NREQ; i++) acks[i] = 0;
        repeat (12) begin
            cycle();
            for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) acks[i]++;
        end
`ifdef JK_PRIO_EN
        chk("t6_acks0", 32'(acks[0]), 32'd4);
        chk("t6_acks2", 32'(acks[2]), 32'd0);
`else
        chk("t6_acks0", 32'(acks[0]), 32'd2);
        chk("t6_acks2", 32'(acks[2]), 32'd2);
`endif
        bus.req_valid = '0;

        // Randomized traffic.
        pulse_reset();
        hold = '0;
        repeat (3000) begin
            cycle();
            rand_drive();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
